// File: rtl/pipeline_fifo_pkg.sv
// Shared constants and helpers for the pipeline FIFO slice.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
// Contents: fifo_clog2() ceiling-log2 constant function, used to size
// pointers and the occupancy counter.
package pipeline_fifo_pkg;

    // Ceiling log2 for elaboration-time sizing; fifo_clog2(1) = 0.
    function automatic int fifo_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width never collapses to zero bits, even for a single entry.
    function automatic int fifo_ptr_w(input int depth);
        return (fifo_clog2(depth) < 1) ? 1 : fifo_clog2(depth);
    endfunction

endpackage

// File: rtl/pipeline_fifo_if.sv
// Enqueue/dequeue/round-tracking bundle between producer, FIFO and consumer.
// Latency: n/a (wiring only).
// Backpressure: producer honours not_full, consumer honours not_empty.
// Signals: enq/enq_value/not_full (producer side), deq/deq_value/not_empty
// (consumer side), reset/consumed/consumed_before (round tracking).
interface pipeline_fifo_if #(
    parameter int width = 0
);
    logic             enq;
    logic [width:0]   enq_value;
    logic             not_full;
    logic             consumed_before;
    logic             reset;
    logic             consumed;
    logic             not_empty;
    logic [width:0]   deq_value;
    logic             deq;

    // master: the surrounding pipeline (producer + consumer rules)
    modport master (
        output enq, enq_value, reset, deq,
        input  not_full, consumed_before, consumed, not_empty, deq_value
    );

    // slave: the FIFO itself
    modport slave (
        input  enq, enq_value, reset, deq,
        output not_full, consumed_before, consumed, not_empty, deq_value
    );
endinterface

// File: rtl/pipeline_fifo_ptr.sv
// Modulo-depth pointer register with increment enable.
// Latency: 1 cycle from inc to updated ptr.
// Backpressure: none; caller gates inc.
// Ports: CLK, RST_N (sync, active-low), inc, ptr.
import pipeline_fifo_pkg::*;

module pipeline_fifo_ptr #(
    parameter int depth = 2,
    parameter int ptr_w = fifo_ptr_w(depth)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [ptr_w-1:0] ptr
);
    // Explicit wrap at depth-1 so non-power-of-two depths work.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == ptr_w'(depth - 1)) ? '0 : ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_fifo.sv
// Pipeline FIFO: dequeue is seen before enqueue, so a full FIFO accepts a same-cycle enq+deq.
// Latency: 1 cycle minimum enq -> deq_value; no combinational enq->deq data path.
// Backpressure: not_full = space left or a dequeue this cycle; illegal enq/deq are ignored.
// Ports: CLK, RST_N (sync, active-low), fifo (pipeline_fifo_if.slave),
// count (occupancy, only when PIPELINE_FIFO_COUNT_EN is defined; that macro
// also enables protocol-violation assertions).
import pipeline_fifo_pkg::*;

module pipeline_fifo #(
    parameter int width = 0,
    parameter int depth = 2,
    localparam int ptr_w = fifo_ptr_w(depth),
    localparam int cnt_w = fifo_clog2(depth + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    pipeline_fifo_if.slave   fifo
`ifdef PIPELINE_FIFO_COUNT_EN
    ,
    output logic [cnt_w-1:0] count
`endif
);
    logic [width:0]   mem [depth];
    logic [ptr_w-1:0] rp;
    logic [ptr_w-1:0] wp;
    logic [cnt_w-1:0] cnt;
    logic             consumed;
    logic             enq_ok;
    logic             deq_ok;

    assign fifo.not_empty       = (cnt != '0);
    assign fifo.deq_value       = mem[rp];
    // Pipeline property: a dequeue this cycle frees the slot the enqueue uses.
    assign fifo.not_full        = (cnt != cnt_w'(depth)) || fifo.deq;
    assign fifo.consumed        = fifo.enq || consumed;
    assign fifo.consumed_before = consumed;

    // Out-of-protocol strobes are dropped so state stays consistent.
    assign enq_ok = fifo.enq && fifo.not_full;
    assign deq_ok = fifo.deq && fifo.not_empty;

    pipeline_fifo_ptr #(.depth(depth), .ptr_w(ptr_w)) u_rp (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (deq_ok),
        .ptr   (rp)
    );

    pipeline_fifo_ptr #(.depth(depth), .ptr_w(ptr_w)) u_wp (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (enq_ok),
        .ptr   (wp)
    );

    // Storage is not reset; entries become invisible once cnt clears.
    // With depth=1 and full, wp==rp: the read of the old head happens this
    // cycle and the write replaces it at the edge.
    always_ff @(posedge CLK) begin
        if (RST_N && enq_ok) begin
            mem[wp] <= fifo.enq_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Round boundary wins over a same-cycle enqueue; the data is still stored.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            consumed <= 1'b0;
        end else if (fifo.reset) begin
            consumed <= 1'b0;
        end else if (enq_ok) begin
            consumed <= 1'b1;
        end
    end

`ifdef PIPELINE_FIFO_COUNT_EN
    assign count = cnt;

    a_enq_full: assert property (@(posedge CLK) disable iff (!RST_N)
        !(fifo.enq && !fifo.not_full))
        else $error("pipeline_fifo: enqueue while full without dequeue");

    a_deq_empty: assert property (@(posedge CLK) disable iff (!RST_N)
        !(fifo.deq && !fifo.not_empty))
        else $error("pipeline_fifo: dequeue while empty");
`endif
endmodule

// File: tb/tb_pipeline_fifo.sv
// Bench for pipeline_fifo: directed checks on a depth-2 instance, then
// in-order streaming and randomized traffic on a depth-3 instance compared
// against a queue reference model.
module tb_pipeline_fifo;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    pipeline_fifo_if #(.width(7)) if2();
    pipeline_fifo_if #(.width(7)) if3();

`ifdef PIPELINE_FIFO_COUNT_EN
    logic [1:0] count2;
    logic [1:0] count3;
    pipeline_fifo #(.width(7), .depth(2)) dut2 (.CLK(CLK), .RST_N(RST_N), .fifo(if2), .count(count2));
    pipeline_fifo #(.width(7), .depth(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .fifo(if3), .count(count3));
`else
    pipeline_fifo #(.width(7), .depth(2)) dut2 (.CLK(CLK), .RST_N(RST_N), .fifo(if2));
    pipeline_fifo #(.width(7), .depth(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .fifo(if3));
`endif

    // Reference model for the depth-3 instance.
    logic [7:0] q3[$];
    logic       cons3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle on the depth-3 instance: drive, check against the model, clock, update model.
    task automatic cyc3(input logic e, input logic [7:0] v, input logic d);
        if3.enq       = e;
        if3.enq_value = v;
        if3.deq       = d;
        #1;
        check("ne3", {31'd0, if3.not_empty}, {31'd0, q3.size() != 0});
        if (q3.size() != 0) check("dv3", {24'd0, if3.deq_value}, {24'd0, q3[0]});
        check("nf3", {31'd0, if3.not_full}, {31'd0, (q3.size() < 3) || d});
        check("cons3", {31'd0, if3.consumed}, {31'd0, e || cons3});
        check("cb3", {31'd0, if3.consumed_before}, {31'd0, cons3});
`ifdef PIPELINE_FIFO_COUNT_EN
        check("cnt3", {30'd0, count3}, q3.size());
`endif
        tick();
        if (d && q3.size() != 0) void'(q3.pop_front());
        if (e) begin
            q3.push_back(v);
            cons3 = 1'b1;
        end
        if3.enq = 1'b0;
        if3.deq = 1'b0;
    endtask

    initial begin
        logic e, d;
        logic [7:0] v;
        if2.enq = 0; if2.enq_value = 0; if2.deq = 0; if2.reset = 0;
        if3.enq = 0; if3.enq_value = 0; if3.deq = 0; if3.reset = 0;
        cons3 = 0;
        RST_N = 0;
        tick();
        tick();
        RST_N = 1;
        #1;
        check("rst_ne", {31'd0, if2.not_empty}, 0);
        check("rst_nf", {31'd0, if2.not_full}, 1);
        check("rst_cb", {31'd0, if2.consumed_before}, 0);
        check("rst_cons", {31'd0, if2.consumed}, 0);
`ifdef PIPELINE_FIFO_COUNT_EN
        check("rst_cnt", {30'd0, count2}, 0);
`endif
        tick();

        // Cycle 1: enqueue 0x11, not yet visible.
        if2.enq = 1; if2.enq_value = 8'h11;
        #1;
        check("c1_ne", {31'd0, if2.not_empty}, 0);
        check("c1_cons", {31'd0, if2.consumed}, 1);
        tick();
        // Cycle 2: 0x11 visible, enqueue 0x22.
        if2.enq_value = 8'h22;
        #1;
        check("c2_ne", {31'd0, if2.not_empty}, 1);
        check("c2_dv", {24'd0, if2.deq_value}, 8'h11);
        check("c2_cb", {31'd0, if2.consumed_before}, 1);
        tick();
        // Cycle 3: full; a dequeue reopens not_full combinationally.
        if2.enq = 0;
        #1;
        check("c3_nf", {31'd0, if2.not_full}, 0);
        if2.deq = 1;
        #1;
        check("c3_nf_deq", {31'd0, if2.not_full}, 1);
        if2.enq = 1; if2.enq_value = 8'h33;
        tick();
        if2.enq = 0; if2.deq = 0;
        #1;
        check("c4_dv", {24'd0, if2.deq_value}, 8'h22);
        check("c4_nf", {31'd0, if2.not_full}, 0);
`ifdef PIPELINE_FIFO_COUNT_EN
        check("c4_cnt", {30'd0, count2}, 2);
`endif
        if2.deq = 1;
        tick();
        #1;
        check("c5_dv", {24'd0, if2.deq_value}, 8'h33);
        check("c5_nf", {31'd0, if2.not_full}, 1);
        tick();
        if2.deq = 0;
        #1;
        check("c6_ne", {31'd0, if2.not_empty}, 0);

        // Round tracking: RESET pulse clears, RESET beats same-cycle ENQ.
        if2.reset = 1;
        tick();
        if2.reset = 0;
        #1;
        check("rnd_clr", {31'd0, if2.consumed_before}, 0);
        if2.enq = 1; if2.reset = 1; if2.enq_value = 8'h44;
        tick();
        if2.enq = 0; if2.reset = 0;
        #1;
        check("rnd_prio_cb", {31'd0, if2.consumed_before}, 0);
        check("rnd_prio_ne", {31'd0, if2.not_empty}, 1);
        check("rnd_prio_dv", {24'd0, if2.deq_value}, 8'h44);
        if2.enq = 1; if2.enq_value = 8'h55;
        #1;
        check("rnd_cons", {31'd0, if2.consumed}, 1);
        tick();
        if2.enq = 0;
        #1;
        check("rnd_cb", {31'd0, if2.consumed_before}, 1);
        check("full_nf", {31'd0, if2.not_full}, 0);

        // Reset with two entries held.
        RST_N = 0;
        tick();
        RST_N = 1;
        #1;
        check("mid_ne", {31'd0, if2.not_empty}, 0);
        check("mid_nf", {31'd0, if2.not_full}, 1);
        check("mid_cb", {31'd0, if2.consumed_before}, 0);
`ifdef PIPELINE_FIFO_COUNT_EN
        check("mid_cnt", {30'd0, count2}, 0);
`endif

        // Depth-3 streaming across pointer wraps: values 1..10 in order.
        for (int k = 1; k <= 10; k++) begin
            cyc3(1'b1, 8'(k), k > 1);
        end
        check("wrap_last", {24'd0, if3.deq_value}, 10);
        cyc3(1'b0, 8'h00, 1'b1);

        // Randomized legal traffic.
        for (int i = 0; i < 400; i++) begin
            d = (q3.size() != 0) && ($urandom_range(0, 99) < 45);
            e = ((q3.size() < 3) || d) && ($urandom_range(0, 99) < 55);
            v = 8'($urandom);
            cyc3(e, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
